// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared width, state type and address-width helper for the neuron feeder
package nn_pkg;

   // Q1.15 fixed point: activations, weights, biases and results
   localparam int Q15_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FEED  = 3'd1,
      WAIT  = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } feeder_state_e;

   // Address width for a space of 'depth' entries; never collapses to zero bits
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// rtl/feeder_addr_gen.sv - beat/neuron counters and running weight-address accumulator
module feeder_addr_gen
   import nn_pkg::*;
#(
   parameter int NUM_INPUTS  = 784,
   parameter int NUM_NEURONS = 10
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       clear_i,
   input  logic                                       step_i,
   input  logic                                       next_neuron_i,
   output logic [addr_width(NUM_INPUTS)-1:0]             beat_o,
   output logic [addr_width(NUM_INPUTS*NUM_NEURONS)-1:0] waddr_o,
   output logic [addr_width(NUM_NEURONS)-1:0]            neuron_o,
   output logic                                       last_beat_o,
   output logic                                       last_neuron_o
);

   localparam int AW = addr_width(NUM_INPUTS);
   localparam int WW = addr_width(NUM_INPUTS * NUM_NEURONS);
   localparam int NW = addr_width(NUM_NEURONS);

   logic [AW-1:0] beat_q, beat_d;
   logic [WW-1:0] waddr_q, waddr_d;
   logic [NW-1:0] neuron_q, neuron_d;

   assign last_beat_o   = (beat_q == AW'(NUM_INPUTS - 1));
   assign last_neuron_o = (neuron_q == NW'(NUM_NEURONS - 1));
   assign beat_o        = beat_q;
   assign waddr_o       = waddr_q;
   assign neuron_o      = neuron_q;

   // Beat wraps per neuron; the weight address keeps running across neurons,
   // so it always equals neuron*NUM_INPUTS + beat without a multiplier
   always_comb begin
      beat_d   = beat_q;
      waddr_d  = waddr_q;
      neuron_d = neuron_q;
      if (clear_i) begin
         beat_d   = '0;
         waddr_d  = '0;
         neuron_d = '0;
      end else begin
         if (step_i) begin
            beat_d  = last_beat_o ? '0 : beat_q + 1'b1;
            waddr_d = waddr_q + 1'b1;
         end
         if (next_neuron_i) begin
            neuron_d = neuron_q + 1'b1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_q   <= '0;
         waddr_q  <= '0;
         neuron_q <= '0;
      end else begin
         beat_q   <= beat_d;
         waddr_q  <= waddr_d;
         neuron_q <= neuron_d;
      end
   end

endmodule

// File: rtl/neuron_feeder.sv
// rtl/neuron_feeder.sv - sequences activation/weight beats into a shared neuron and stores results
module neuron_feeder
   import nn_pkg::*;
#(
   parameter int IN_WIDTH    = Q15_WIDTH,
   parameter int NUM_INPUTS  = 784,
   parameter int NUM_NEURONS = 10,
   parameter int TIMEOUT     = 15
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       start,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       error,
   output logic [addr_width(NUM_INPUTS)-1:0]             act_addr,
   input  logic [IN_WIDTH-1:0]                        act_rdata,
   output logic [addr_width(NUM_INPUTS*NUM_NEURONS)-1:0] wgt_addr,
   input  logic [IN_WIDTH-1:0]                        wgt_rdata,
   output logic [addr_width(NUM_NEURONS)-1:0]            bias_addr,
   input  logic [IN_WIDTH-1:0]                        bias_rdata,
   output logic [IN_WIDTH-1:0]                        data_out,
   output logic [IN_WIDTH-1:0]                        weight_out,
   output logic [IN_WIDTH-1:0]                        bias_out,
   output logic                                       valid_out,
   input  logic [IN_WIDTH-1:0]                        neuron_result,
   input  logic                                       neuron_valid,
   output logic [addr_width(NUM_NEURONS)-1:0]            res_addr,
   output logic [IN_WIDTH-1:0]                        res_data,
   output logic                                       res_we
);

   localparam int TW = addr_width(TIMEOUT);

   feeder_state_e        state_q, state_d;
   logic [TW-1:0]        wait_q, wait_d;
   logic                 error_q, error_d;
   logic [IN_WIDTH-1:0]  result_q, result_d;
   logic                 valid_q;

   logic                 clear;
   logic                 step;
   logic                 next_neuron;
   logic                 last_beat;
   logic                 last_neuron;
   logic [addr_width(NUM_NEURONS)-1:0] neuron;

   feeder_addr_gen #(
      .NUM_INPUTS  (NUM_INPUTS),
      .NUM_NEURONS (NUM_NEURONS)
   ) u_addr_gen (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .clear_i       (clear),
      .step_i        (step),
      .next_neuron_i (next_neuron),
      .beat_o        (act_addr),
      .waddr_o       (wgt_addr),
      .neuron_o      (neuron),
      .last_beat_o   (last_beat),
      .last_neuron_o (last_neuron)
   );

   // Next state and counter controls; a timeout leaves through DONE so the
   // host still sees a done pulse, with error marking the run as aborted
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      error_d     = error_q;
      result_d    = result_q;
      clear       = 1'b0;
      step        = 1'b0;
      next_neuron = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               clear   = 1'b1;
               error_d = 1'b0;
               state_d = FEED;
            end
         end
         FEED: begin
            step = 1'b1;
            if (last_beat) begin
               wait_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (neuron_valid) begin
               result_d = neuron_result;
               state_d  = STORE;
            end else if (wait_q == TW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         STORE: begin
            if (last_neuron) begin
               state_d = DONE;
            end else begin
               next_neuron = 1'b1;
               state_d     = FEED;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, wait counter, sticky error, captured result and beat-valid delay
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         error_q  <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         error_q  <= error_d;
         result_q <= result_d;
         valid_q  <= step;
      end
   end

   // Read data lands one cycle after its address, aligned with valid_q; gating
   // keeps the neuron-facing bus at zero between beats and during reset
   assign valid_out  = valid_q;
   assign data_out   = valid_q ? act_rdata  : '0;
   assign weight_out = valid_q ? wgt_rdata  : '0;
   assign bias_out   = valid_q ? bias_rdata : '0;
   assign bias_addr  = neuron;

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign error    = error_q;
   assign res_we   = (state_q == STORE);
   assign res_addr = neuron;
   assign res_data = result_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// tb/tb_neuron_feeder.sv - scoreboard bench for neuron_feeder with a behavioural Q1.15 neuron
module tb_neuron_feeder;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int M  = 2;
   localparam int TO = 6;
   localparam int AW = $clog2(N);
   localparam int WW = $clog2(N * M);
   localparam int NW = 1;

   typedef struct packed { int addr; int data; } res_t;
   typedef struct packed { int aa; int wa; int d; int w; int b; } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, error, valid_out, res_we;
   logic [AW-1:0] act_addr;
   logic [WW-1:0] wgt_addr;
   logic [NW-1:0] bias_addr, res_addr;
   logic [W-1:0]  act_rdata, wgt_rdata, bias_rdata;
   logic [W-1:0]  data_out, weight_out, bias_out, res_data;
   logic [W-1:0]  neuron_result;
   logic          neuron_valid;
   logic          silent = 1'b0;

   logic [W-1:0]  act_mem  [N];
   logic [W-1:0]  wgt_mem  [N*M];
   logic [W-1:0]  bias_mem [M];

   int n_cmp = 0, n_fail = 0;
   int cyc = 0, s_cyc = 0, done_cnt = 0, we_cnt = 0, done_cyc = 0;
   int act_prev = 0, wgt_prev = 0, run_len = 0;
   bit err_at_done = 1'b0;

   res_t  exp_res[$], obs_res[$];
   beat_t exp_beat[$], obs_beat[$];
   int    runs[$];

   neuron_feeder #(
      .IN_WIDTH    (W),
      .NUM_INPUTS  (N),
      .NUM_NEURONS (M),
      .TIMEOUT     (TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .act_addr      (act_addr),
      .act_rdata     (act_rdata),
      .wgt_addr      (wgt_addr),
      .wgt_rdata     (wgt_rdata),
      .bias_addr     (bias_addr),
      .bias_rdata    (bias_rdata),
      .data_out      (data_out),
      .weight_out    (weight_out),
      .bias_out      (bias_out),
      .valid_out     (valid_out),
      .neuron_result (neuron_result),
      .neuron_valid  (neuron_valid),
      .res_addr      (res_addr),
      .res_data      (res_data),
      .res_we        (res_we)
   );

   always #5 clk = ~clk;

   function automatic int prod(input logic [W-1:0] a, input logic [W-1:0] w);
      int sa, sw;
      sa = int'($signed(a));
      sw = int'($signed(w));
      return (sa * sw) >>> 15;
   endfunction

   function automatic int relu_sat(input int sum, input logic [W-1:0] b);
      int s;
      s = sum + int'($signed(b));
      if (s < 0) s = 0;
      else if (s > 32767) s = 32767;
      return s;
   endfunction

   function automatic int model_neuron(input int n);
      int sum;
      sum = 0;
      for (int i = 0; i < N; i++) sum += prod(act_mem[i], wgt_mem[n*N+i]);
      return relu_sat(sum, bias_mem[n]);
   endfunction

   // Synchronous-read memories
   always @(posedge clk) begin
      act_rdata  <= act_mem[act_addr];
      wgt_rdata  <= wgt_mem[wgt_addr];
      bias_rdata <= bias_mem[bias_addr];
   end

   // Behavioural neuron: MAC over N beats, bias, ReLU, result one cycle after last beat
   int nacc, ncnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nacc <= 0; ncnt <= 0; neuron_valid <= 1'b0; neuron_result <= '0;
      end else begin
         neuron_valid <= 1'b0;
         if (valid_out) begin
            if (ncnt == N-1) begin
               ncnt <= 0;
               nacc <= 0;
               if (!silent) begin
                  neuron_valid  <= 1'b1;
                  neuron_result <= 16'(relu_sat(nacc + prod(data_out, weight_out), bias_out));
               end
            end else begin
               ncnt <= ncnt + 1;
               nacc <= nacc + prod(data_out, weight_out);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      cyc++;
      if (res_we) begin
         obs_res.push_back('{int'(res_addr), int'(res_data)});
         we_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc    = cyc;
         err_at_done = error;
      end
      if (valid_out) begin
         obs_beat.push_back('{act_prev, wgt_prev, int'(data_out), int'(weight_out), int'(bias_out)});
         run_len++;
      end else if (run_len != 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
      act_prev = int'(act_addr);
      wgt_prev = int'(wgt_addr);
   endtask

   task automatic launch();
      exp_res.delete(); obs_res.delete(); exp_beat.delete(); obs_beat.delete(); runs.delete();
      run_len = 0;
      for (int n = 0; n < M; n++) begin
         for (int i = 0; i < N; i++)
            exp_beat.push_back('{i, n*N+i, int'(act_mem[i]), int'(wgt_mem[n*N+i]), int'(bias_mem[n])});
         exp_res.push_back('{n, model_neuron(n)});
      end
      start = 1'b1;
      s_cyc = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) step();
      timed_out = (done_cnt == d0);
      step();
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_cmp++;
      if ({busy, done, error, valid_out, res_we, act_addr, wgt_addr, bias_addr,
           data_out, weight_out, bias_out, res_addr, res_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b err=%b vo=%b we=%b act=%0d wgt=%0d", busy, done, error, valid_out, res_we, act_addr, wgt_addr);
      end
      rst_n = 1'b1;
      repeat (2) step();
      n_cmp++;
      if ({busy, done, error, valid_out, res_we} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want 00000", {busy, done, error, valid_out, res_we});
      end
   endtask

   task automatic test_two_neurons();
      bit to;
      res_t ro;
      beat_t bo, be;
      for (int i = 0; i < N; i++) act_mem[i] = 16'((i + 1) * 16'h0400);
      for (int i = 0; i < N*M; i++) wgt_mem[i] = 16'h4000;
      for (int n = 0; n < M; n++) bias_mem[n] = 16'h0000;
      launch();
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy); end
      wait_done(60, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL t1_done_timeout: got none want done"); end
      n_cmp++;
      if (done_cyc - s_cyc !== 15) begin n_fail++; $display("FAIL t1_done_cycle: got %0d want 15", done_cyc - s_cyc); end
      n_cmp++;
      if (obs_res.size() !== M) begin n_fail++; $display("FAIL t1_res_count: got %0d want %0d", obs_res.size(), M); end
      for (int n = 0; n < M && obs_res.size() != 0; n++) begin
         ro = obs_res.pop_front();
         n_cmp++;
         if (ro.addr !== n || ro.data !== 32'h1400) begin
            n_fail++; $display("FAIL t1_res: got addr=%0d data=%h want addr=%0d data=1400", ro.addr, ro.data, n);
         end
      end
      n_cmp++;
      if (runs.size() !== M) begin n_fail++; $display("FAIL t2_valid_runs: got %0d want %0d", runs.size(), M); end
      foreach (runs[k]) begin
         n_cmp++;
         if (runs[k] !== N) begin n_fail++; $display("FAIL t2_valid_len: got %0d want %0d", runs[k], N); end
      end
      n_cmp++;
      if (obs_beat.size() !== exp_beat.size()) begin
         n_fail++; $display("FAIL t2_beat_count: got %0d want %0d", obs_beat.size(), exp_beat.size());
      end
      for (int k = 0; obs_beat.size() != 0 && exp_beat.size() != 0; k++) begin
         bo = obs_beat.pop_front();
         be = exp_beat.pop_front();
         n_cmp++;
         if (bo !== be) begin
            n_fail++; $display("FAIL t2_beat%0d: got aa=%0d wa=%0d d=%h w=%h b=%h want aa=%0d wa=%0d d=%h w=%h b=%h",
                               k, bo.aa, bo.wa, bo.d, bo.w, bo.b, be.aa, be.wa, be.d, be.w, be.b);
         end
         if (k >= N) begin
            n_cmp++;
            if (bo.wa !== k) begin n_fail++; $display("FAIL t2_wgt_addr_n1: got %0d want %0d", bo.wa, k); end
         end
      end
   endtask

   task automatic test_restart_ignored();
      bit to;
      int d0, w0;
      res_t ro, re;
      d0 = done_cnt;
      w0 = we_cnt;
      launch();
      step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(60, to);
      repeat (10) step();
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL t3_done_timeout: got none want done"); end
      n_cmp++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL t3_done_pulses: got %0d want 1", done_cnt - d0); end
      n_cmp++;
      if (we_cnt - w0 !== M) begin n_fail++; $display("FAIL t3_we_pulses: got %0d want %0d", we_cnt - w0, M); end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_idle: busy got %b want 0", busy); end
      while (obs_res.size() != 0 && exp_res.size() != 0) begin
         ro = obs_res.pop_front();
         re = exp_res.pop_front();
         n_cmp++;
         if (ro !== re) begin n_fail++; $display("FAIL t3_res: got %0d/%h want %0d/%h", ro.addr, ro.data, re.addr, re.data); end
      end
   endtask

   task automatic test_timeout();
      bit to;
      int w0;
      res_t ro, re;
      silent = 1'b1;
      w0 = we_cnt;
      launch();
      wait_done(60, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL t4_done_timeout: got none want done"); end
      n_cmp++;
      if (done_cyc - s_cyc !== 5 + TO) begin n_fail++; $display("FAIL t4_done_cycle: got %0d want %0d", done_cyc - s_cyc, 5 + TO); end
      n_cmp++;
      if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL t4_error_at_done: got %b want 1", err_at_done); end
      n_cmp++;
      if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL t4_no_we: got %0d want 0", we_cnt - w0); end
      repeat (3) step();
      n_cmp++;
      if (error !== 1'b1) begin n_fail++; $display("FAIL t4_error_sticky: got %b want 1", error); end
      silent = 1'b0;
      launch();
      n_cmp++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL t4_error_cleared: got %b want 0", error); end
      wait_done(60, to);
      n_cmp++;
      if (to || err_at_done !== 1'b0) begin n_fail++; $display("FAIL t4_rerun: timeout=%b err=%b want 0 0", to, err_at_done); end
      n_cmp++;
      if (obs_res.size() !== M) begin n_fail++; $display("FAIL t4_res_count: got %0d want %0d", obs_res.size(), M); end
      while (obs_res.size() != 0 && exp_res.size() != 0) begin
         ro = obs_res.pop_front();
         re = exp_res.pop_front();
         n_cmp++;
         if (ro !== re) begin n_fail++; $display("FAIL t4_res: got %0d/%h want %0d/%h", ro.addr, ro.data, re.addr, re.data); end
      end
   endtask

   task automatic test_reset_midrun();
      bit to;
      int d0, w0;
      res_t ro, re;
      d0 = done_cnt;
      w0 = we_cnt;
      launch();
      while (cyc < s_cyc + 9) step();
      n_cmp++;
      if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL t5_first_store: got %0d want 1", we_cnt - w0); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, error, valid_out, res_we, act_addr, wgt_addr, bias_addr,
           data_out, weight_out, bias_out, res_addr, res_data} !== '0) begin
         n_fail++;
         $display("FAIL t5_outputs_cleared: busy=%b vo=%b act=%0d wgt=%0d bias_addr=%0d d=%h w=%h",
                  busy, valid_out, act_addr, wgt_addr, bias_addr, data_out, weight_out);
      end
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();
      n_cmp++;
      if (done_cnt !== d0 || we_cnt - w0 !== 1) begin
         n_fail++; $display("FAIL t5_no_done_no_we: got done=%0d we=%0d want 0 1", done_cnt - d0, we_cnt - w0);
      end
      launch();
      wait_done(60, to);
      n_cmp++;
      if (to || done_cyc - s_cyc !== 15) begin n_fail++; $display("FAIL t5_clean_run: timeout=%b cycle=%0d want 0 15", to, done_cyc - s_cyc); end
      n_cmp++;
      if (obs_res.size() !== M) begin n_fail++; $display("FAIL t5_res_count: got %0d want %0d", obs_res.size(), M); end
      while (obs_res.size() != 0 && exp_res.size() != 0) begin
         ro = obs_res.pop_front();
         re = exp_res.pop_front();
         n_cmp++;
         if (ro !== re) begin n_fail++; $display("FAIL t5_res: got %0d/%h want %0d/%h", ro.addr, ro.data, re.addr, re.data); end
      end
   endtask

   task automatic test_negative_bias();
      bit to;
      res_t ro, re;
      beat_t bo;
      for (int i = 0; i < N; i++) act_mem[i] = 16'($urandom_range(16'h0000, 16'h0fff));
      for (int i = 0; i < N; i++) wgt_mem[i] = 16'h2000;
      for (int i = N; i < N*M; i++) wgt_mem[i] = 16'h4000;
      bias_mem[0] = 16'h0100;
      bias_mem[1] = 16'h9000;
      launch();
      wait_done(60, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL t6_done_timeout: got none want done"); end
      n_cmp++;
      if (obs_res.size() !== M) begin n_fail++; $display("FAIL t6_res_count: got %0d want %0d", obs_res.size(), M); end
      while (obs_res.size() != 0 && exp_res.size() != 0) begin
         ro = obs_res.pop_front();
         re = exp_res.pop_front();
         n_cmp++;
         if (ro !== re) begin n_fail++; $display("FAIL t6_res: got %0d/%h want %0d/%h", ro.addr, ro.data, re.addr, re.data); end
         if (ro.addr == 1) begin
            n_cmp++;
            if (ro.data !== 0) begin n_fail++; $display("FAIL t6_relu_zero: got %h want 0000", ro.data); end
         end
      end
      n_cmp++;
      if (obs_beat.size() !== N*M) begin n_fail++; $display("FAIL t6_beat_count: got %0d want %0d", obs_beat.size(), N*M); end
      for (int k = 0; obs_beat.size() != 0; k++) begin
         bo = obs_beat.pop_front();
         n_cmp++;
         if (bo.b !== int'(bias_mem[k / N])) begin
            n_fail++; $display("FAIL t6_bias_stable beat%0d: got %h want %h", k, bo.b, bias_mem[k / N]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_neurons();
      test_restart_ignored();
      test_timeout();
      test_reset_midrun();
      test_negative_bias();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
